// File: rtl/verdict_pkg.sv
// Shared constants and types for the monitor verdict collector.
// Header layout: timestamp in the top TS_W bits, active mask from bit 0.
package verdict_pkg;

    localparam logic [3:0] HDR_ID   = 4'hF;
    localparam int         MASK_LSB = 0;

    function automatic int ts_lsb(input int data_w, input int ts_w);
        return data_w - ts_w;
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA
    } ser_state_t;

endpackage

// File: rtl/snapshot_fifo.sv
// Snapshot FIFO with registered read port; rd_dat always shows the head entry.
// Latency: a push into an empty FIFO is visible on rd_dat after the same edge.
// Backpressure: caller must not push when full nor pop when empty.
module snapshot_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic         one_left,
    output logic [W-1:0] rd_dat
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0] mem [DEPTH];
    logic [AW:0]  wr_ptr;
    logic [AW:0]  rd_ptr;
    logic [AW:0]  rd_ptr_nxt;

    assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, pop};
    assign empty      = (wr_ptr == rd_ptr);
    assign full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign one_left   = ((wr_ptr - rd_ptr) == {{AW{1'b0}}, 1'b1});

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            rd_ptr <= rd_ptr_nxt;
        end
    end

    // Bypass covers a push landing in the slot that becomes the new head.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= push_dat;
        if (push && (wr_ptr[AW-1:0] == rd_ptr_nxt[AW-1:0]))
            rd_dat <= push_dat;
        else
            rd_dat <= mem[rd_ptr_nxt[AW-1:0]];
    end

endmodule

// File: rtl/verdict_collector.sv
// Captures timestamped monitor verdict snapshots and streams them as header + active values.
// Latency: header valid one cycle after the capture edge when idle; k+1 words per snapshot.
// Backpressure: words hold on tx_ready=0; captures into a full FIFO are dropped and counted.
module verdict_collector
    import verdict_pkg::*;
#(
    parameter int NUM_OUT = 8,
    parameter int DATA_W  = 64,
    parameter int TS_W    = 32,
    parameter int DEPTH   = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      en,
    input  logic [NUM_OUT*DATA_W-1:0] out_data,
    input  logic [NUM_OUT-1:0]        out_aktv,
    output logic                      tx_valid,
    input  logic                      tx_ready,
    output logic [DATA_W-1:0]         tx_data,
    output logic [3:0]                tx_id,
    output logic                      tx_last,
    output logic                      overflow,
    output logic [15:0]               drop_count
);

    localparam int SNAP_W = TS_W + NUM_OUT + NUM_OUT * DATA_W;
    localparam int TS_LSB = ts_lsb(DATA_W, TS_W);

    logic [TS_W-1:0]    ts;
    logic               capture, push, drop, pop;
    logic               full, empty, one_left;
    logic [SNAP_W-1:0]  rd_dat;
    logic [TS_W-1:0]    snap_ts;
    logic [NUM_OUT-1:0] snap_mask;
    ser_state_t         state, state_nxt;
    logic [3:0]         idx, idx_nxt, hit_idx;
    logic [4:0]         search_from;
    logic               found;

    assign capture   = en && (|out_aktv);
    assign push      = capture && !full;
    assign drop      = capture && full;
    assign snap_ts   = rd_dat[SNAP_W-1 -: TS_W];
    assign snap_mask = rd_dat[NUM_OUT*DATA_W +: NUM_OUT];

    snapshot_fifo #(
        .W     (SNAP_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .push_dat ({ts, out_aktv, out_data}),
        .pop      (pop),
        .full     (full),
        .empty    (empty),
        .one_left (one_left),
        .rd_dat   (rd_dat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ts         <= '0;
            overflow   <= 1'b0;
            drop_count <= '0;
            state      <= IDLE;
            idx        <= '0;
        end else begin
            if (en) ts <= ts + 1'b1;
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != 16'hFFFF) drop_count <= drop_count + 16'd1;
            end
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    // Lowest set mask bit at or above search_from: first value from HDR, next value from DATA.
    always_comb begin
        search_from = (state == DATA) ? ({1'b0, idx} + 5'd1) : 5'd0;
        found       = 1'b0;
        hit_idx     = '0;
        for (int i = NUM_OUT - 1; i >= 0; i--) begin
            if (snap_mask[i] && (5'(i) >= search_from)) begin
                found   = 1'b1;
                hit_idx = 4'(i);
            end
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        pop       = 1'b0;
        tx_valid  = 1'b0;
        tx_data   = '0;
        tx_id     = '0;
        tx_last   = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) state_nxt = HDR;
            end
            HDR: begin
                tx_valid                    = 1'b1;
                tx_data[TS_LSB +: TS_W]     = snap_ts;
                tx_data[MASK_LSB +: NUM_OUT] = snap_mask;
                tx_id                       = HDR_ID;
                if (tx_ready) begin
                    state_nxt = DATA;
                    idx_nxt   = hit_idx;
                end
            end
            DATA: begin
                tx_valid = 1'b1;
                tx_data  = rd_dat[int'(idx) * DATA_W +: DATA_W];
                tx_id    = idx;
                tx_last  = !found;
                if (tx_ready) begin
                    if (found) begin
                        idx_nxt = hit_idx;
                    end else begin
                        pop       = 1'b1;
                        state_nxt = (!one_left || push) ? HDR : IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_verdict_collector.sv
// Directed bench for verdict_collector: latency, backpressure, overflow, reset and en gating.
module tb_verdict_collector;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         en;
    logic [511:0] out_data;
    logic [7:0]   out_aktv;
    logic         tx_valid;
    logic         tx_ready;
    logic [63:0]  tx_data;
    logic [3:0]   tx_id;
    logic         tx_last;
    logic         overflow;
    logic [15:0]  drop_count;

    int n_chk  = 0;
    int n_pass = 0;

    verdict_collector #(
        .NUM_OUT (8),
        .DATA_W  (64),
        .TS_W    (32),
        .DEPTH   (16)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .out_data   (out_data),
        .out_aktv   (out_aktv),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .tx_data    (tx_data),
        .tx_id      (tx_id),
        .tx_last    (tx_last),
        .overflow   (overflow),
        .drop_count (drop_count)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [63:0] hdr(input logic [31:0] t, input logic [7:0] m);
        logic [63:0] h;
        h        = '0;
        h[63:32] = t;
        h[7:0]   = m;
        return h;
    endfunction

    // Compares {valid, id, last, data} of the link in one go.
    task automatic word(input string tag, input logic v, input logic [3:0] id,
                        input logic last, input logic [63:0] d);
        chk(tag, {10'b0, tx_valid, tx_id, tx_last, tx_data}, {10'b0, v, id, last, d});
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        out_data = '0;
        out_aktv = '0;
        tx_ready = 1'b0;
        step();
        step();
        word("reset_link", 1'b0, 4'h0, 1'b0, 64'h0);
        chk("reset_ovf", {79'b0, overflow}, 80'd0);
        chk("reset_drops", {64'b0, drop_count}, 80'd0);
        rst_n = 1'b1;

        // Basic frame: ts 500, outputs 0 and 2.
        en       = 1'b1;
        tx_ready = 1'b1;
        repeat (500) step();
        out_aktv          = 8'h05;
        out_data[0+:64]   = 64'd1;
        out_data[128+:64] = -64'sd3;
        step();
        out_aktv = '0;
        en       = 1'b0;
        word("t1_latency", 1'b0, 4'h0, 1'b0, 64'h0);
        step();
        word("t1_hdr", 1'b1, 4'hF, 1'b0, hdr(32'd500, 8'h05));
        step();
        word("t1_w0", 1'b1, 4'h0, 1'b0, 64'd1);
        step();
        word("t1_w2", 1'b1, 4'h2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD);
        step();
        word("t1_idle", 1'b0, 4'h0, 1'b0, 64'h0);

        // Same frame held off for 5 cycles.
        tx_ready = 1'b0;
        en       = 1'b1;
        out_aktv = 8'h05;
        step();
        out_aktv = '0;
        en       = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            word("t2_hold", 1'b1, 4'hF, 1'b0, hdr(32'd501, 8'h05));
            step();
        end
        tx_ready = 1'b1;
        word("t2_hdr", 1'b1, 4'hF, 1'b0, hdr(32'd501, 8'h05));
        step();
        word("t2_w0", 1'b1, 4'h0, 1'b0, 64'd1);
        step();
        word("t2_w2", 1'b1, 4'h2, 1'b1, 64'hFFFF_FFFF_FFFF_FFFD);
        step();
        word("t2_idle", 1'b0, 4'h0, 1'b0, 64'h0);

        // 20 captures into a stalled 16-deep FIFO (ts 502..521).
        tx_ready        = 1'b0;
        out_data[0+:64] = 64'd7;
        en              = 1'b1;
        out_aktv        = 8'h01;
        repeat (20) step();
        en       = 1'b0;
        out_aktv = '0;
        chk("t3_ovf", {79'b0, overflow}, 80'd1);
        chk("t3_drops", {64'b0, drop_count}, 80'd4);
        tx_ready = 1'b1;
        for (int f = 0; f < 16; f++) begin
            word("t3_hdr", 1'b1, 4'hF, 1'b0, hdr(32'(502 + f), 8'h01));
            step();
            word("t3_w0", 1'b1, 4'h0, 1'b1, 64'd7);
            step();
        end
        word("t3_empty", 1'b0, 4'h0, 1'b0, 64'h0);

        // Refill (ts 522..537), then capture on the edge that pops the final word.
        tx_ready = 1'b0;
        en       = 1'b1;
        out_aktv = 8'h01;
        repeat (16) step();
        en       = 1'b0;
        out_aktv = '0;
        tx_ready = 1'b1;
        word("t4_hdr", 1'b1, 4'hF, 1'b0, hdr(32'd522, 8'h01));
        step();
        word("t4_last", 1'b1, 4'h0, 1'b1, 64'd7);
        en       = 1'b1;
        out_aktv = 8'h01;
        step();
        en       = 1'b0;
        out_aktv = '0;
        chk("t4_drops", {64'b0, drop_count}, 80'd5);
        for (int f = 0; f < 15; f++) begin
            word("t4_drain", 1'b1, 4'hF, 1'b0, hdr(32'(523 + f), 8'h01));
            step();
            step();
        end
        word("t4_empty", 1'b0, 4'h0, 1'b0, 64'h0);

        // Reset in the middle of an 8-output frame (ts 539).
        for (int i = 0; i < 8; i++) out_data[i*64 +: 64] = 64'(100 + i);
        en       = 1'b1;
        out_aktv = 8'hFF;
        step();
        en       = 1'b0;
        out_aktv = '0;
        step();
        word("t5_hdr", 1'b1, 4'hF, 1'b0, hdr(32'd539, 8'hFF));
        step();
        word("t5_w0", 1'b1, 4'h0, 1'b0, 64'd100);
        step();
        word("t5_w1", 1'b1, 4'h1, 1'b0, 64'd101);
        #2;
        rst_n = 1'b0;
        #1;
        word("t5_rst_link", 1'b0, 4'h0, 1'b0, 64'h0);
        chk("t5_rst_ovf", {79'b0, overflow}, 80'd0);
        chk("t5_rst_drops", {64'b0, drop_count}, 80'd0);
        step();
        step();
        rst_n    = 1'b1;
        en       = 1'b1;
        out_aktv = 8'h01;
        step();
        en       = 1'b0;
        out_aktv = '0;
        step();
        word("t5_ts0_hdr", 1'b1, 4'hF, 1'b0, hdr(32'd0, 8'h01));
        step();
        word("t5_ts0_w0", 1'b1, 4'h0, 1'b1, 64'd100);
        step();
        word("t5_idle", 1'b0, 4'h0, 1'b0, 64'h0);

        // en low for 10 cycles while a frame (outputs 1, 3; ts 1) drains.
        out_data[64+:64]  = 64'd11;
        out_data[192+:64] = 64'd33;
        en       = 1'b1;
        out_aktv = 8'h0A;
        step();
        en       = 1'b0;
        out_aktv = 8'hFF;
        step();
        word("t6_hdr", 1'b1, 4'hF, 1'b0, hdr(32'd1, 8'h0A));
        step();
        word("t6_w1", 1'b1, 4'h1, 1'b0, 64'd11);
        step();
        word("t6_w3", 1'b1, 4'h3, 1'b1, 64'd33);
        for (int i = 0; i < 7; i++) begin
            step();
            word("t6_ignored", 1'b0, 4'h0, 1'b0, 64'h0);
        end
        en       = 1'b1;
        out_aktv = 8'h01;
        step();
        en       = 1'b0;
        out_aktv = '0;
        step();
        word("t6_ts_held", 1'b1, 4'hF, 1'b0, hdr(32'd2, 8'h01));
        step();
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/verdict_collector.md
# verdict_collector

Consumes the per-cycle verdict interface of the compiled monitor (`output_N` values with `output_N_aktv` flags). On every cycle in which any output is active, it captures a timestamped snapshot into a FIFO. A serializer then streams each snapshot as a header word followed by one word per active output over a valid/ready link. The block sits between `topEntity` and the host/trace sink, and replaces bench-side `$display` collection in hardware runs.

## Interface
- `NUM_OUT`, default 8: number of monitor outputs; range 1..15.
- `DATA_W`, default 64: width of each output value and of `tx_data`.
- `TS_W`, default 32: timestamp width. Must satisfy `TS_W + NUM_OUT <= DATA_W`.
- `DEPTH`, default 16: snapshot FIFO depth; power of two, at least 2.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: enables capture and advances the timestamp.
- `out_data` in `NUM_OUT*DATA_W`: monitor output values; output i occupies bits `[i*DATA_W +: DATA_W]`, signed.
- `out_aktv` in `NUM_OUT`: bit i is `output_i_aktv`.
- `tx_valid` out 1: the word on the link is valid.
- `tx_ready` in 1: the sink accepts the word.
- `tx_data` out `DATA_W`: header or value word.
- `tx_id` out 4: `HDR_ID` (4'hF) for a header word; otherwise the output index.
- `tx_last` out 1: marks the final word of a snapshot.
- `overflow` out 1: sticky flag, set when a snapshot is dropped.
- `drop_count` out 16: saturating count of dropped snapshots.

## Operation
- **Timestamp counter `ts`**
  - Reset value 0.
  - Increments by 1 on each cycle with `en`=1; holds otherwise.
  - Wraps modulo 2^TS_W.
- **Capture**
  - A capture occurs on the rising edge where `en`=1 and `|out_aktv`=1.
  - The snapshot is {`ts` current value, `mask`=`out_aktv`, the `out_data` words whose mask bit is set}.
  - Inactive values are not stored, or are stored but never sent.
- **FIFO full**
  - If the FIFO is full at that edge, the snapshot is dropped, `overflow` is set, and `drop_count` increments, saturating at 16'hFFFF.
  - Full is evaluated before any same-edge pop. A capture arriving while full is dropped even if a pop completes on the same edge.
- **Serializer FSM states**
  - IDLE: FIFO empty, `tx_valid`=0. Goes to HDR when the FIFO is non-empty.
  - HDR
    - Drives `tx_data` = {zeros, `ts` in `[DATA_W-1 -: TS_W]`, `mask` in `[NUM_OUT-1:0]`} and `tx_id`=4'hF; `tx_last`=0.
    - On handshake, goes to DATA with the index set to the lowest set bit of `mask`.
  - DATA
    - Drives the value of the current index, with `tx_id`=index.
    - `tx_last`=1 when no higher mask bit is set.
    - On handshake:
      - if another mask bit is set, advance to the next-higher set bit;
      - otherwise pop the FIFO, then go to HDR if non-empty, else IDLE.
- **Handshake rules**
  - A transfer happens on an edge with `tx_valid`&&`tx_ready`.
  - While `tx_valid`=1 and `tx_ready`=0, `tx_data`, `tx_id` and `tx_last` hold stable.
  - `tx_valid` never drops without a transfer.
- **`en`**: gates only capture and `ts`. The serializer keeps draining when `en`=0.
- **Reset** (asserted at any time, including mid-frame)
  - Immediately: `tx_valid`=0, `tx_data`=0, `tx_id`=0, `tx_last`=0, `overflow`=0, `drop_count`=0.
  - FIFO emptied, FSM to IDLE, `ts`=0.
  - A partially sent frame is abandoned; there is no resume after reset.

## Timing
- Capture on edge N with an empty FIFO and IDLE FSM: `tx_valid` rises with the header after edge N+1, because the FIFO read is registered. Latency is 1 cycle from capture edge to header valid.
- With `tx_ready` held at 1, a snapshot with k active outputs occupies k+1 consecutive cycles. The next snapshot's header follows in the cycle after `tx_last` with no bubble.
- Sustained throughput under continuous captures is one snapshot per (k+1) cycles. Excess captures fill the FIFO and are then dropped.

## Structure
- Package `verdict_pkg` holds:
  - `HDR_ID` (4'hF);
  - the header field positions (`TS_LSB` = `DATA_W-TS_W`, mask at bit 0);
  - the FSM state enum {IDLE, HDR, DATA}.
- Sub-module `snapshot_fifo`
  - Synchronous FIFO, `DEPTH` entries × (`TS_W+NUM_OUT+NUM_OUT*DATA_W`) bits.
  - Registered read, full/empty flags.
  - Reset clears the pointers only.
- Top level holds the `ts` counter, the drop logic, and the serializer FSM with its next-set-bit priority encoder.

## Test plan
- Reset, then after 500 idle `en` cycles assert `out_aktv`=8'b0000_0101 for one cycle with `output_0`=1 and `output_2`=-3, `tx_ready`=1. Expected, in order: header (ts=500, mask=8'h05, id=F); word 1 (`tx_data`=1, id=0); word 2 (`tx_data`=-3, id=2, `tx_last`=1).
- Same stimulus with `tx_ready`=0 for 5 cycles. Expected: header held stable with `tx_valid`=1 for all 5 cycles, then the same three words.
- `tx_ready`=0 and 20 consecutive captures with mask 8'h01 at `DEPTH`=16. Expected: `overflow`=1 and `drop_count`=4. Releasing `tx_ready` then drains exactly 16 frames with consecutive timestamps.
- Full FIFO, with a capture and a final-word pop on the same edge. Expected: the capture is dropped and `drop_count` increments.
- Assert `rst_n`=0 mid-DATA of an 8-output frame. Expected: all outputs at their reset values immediately. After release, the first captured frame carries ts from 0.
- `en`=0 for 10 cycles while a frame drains. Expected: the drain completes, `ts` holds, and `out_aktv`=8'hFF is ignored.
